seq_gen: RTL and testbench

- Programmable bit-serial pattern generator; the transmit-side counterpart of the sequence detector.
- Serializes a configurable 1..MAX_LEN-bit pattern, MSB-first (pattern[seq_len-1] down to pattern[0]), on a single data line with a valid strobe.
- Supports repeated frames with an optional idle gap between them.
- Drives the detector's serial data input for loopback and self-test.

---
 rtl/seq_pkg.sv | 26 ++
 rtl/seq_gen.sv | 215 +++++++++++++++++++++
 tb/tb_seq_gen.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Definitions shared by the serial pattern generator (seq_gen) and the
// sequence detector that it drives in loopback.
//   state_t   : IDLE / SEND / GAP state encoding
//   MAX_LEN   : longest supported pattern, in bits
//   LEN_W     : width of a sequence-length field
//   len_legal : 1 when a requested length lies in 1..max_len
// -----------------------------------------------------------------------------
package seq_pkg;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic len_legal(input int unsigned len,
                                       input int unsigned max_len = MAX_LEN);
        return (len != 0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen
// Programmable bit-serial pattern generator. On start it captures a pattern
// of seq_len bits and shifts it out MSB-first (pattern[seq_len-1] first),
// one bit per enabled cycle, for repeat_cnt+1 frames with gap_len idle
// cycles between frames. Every output is registered.
//
// Ports
//   clk         system clock
//   rst_n       synchronous active-low reset
//   ena         global enable; 0 freezes all state
//   start       begin a transfer (only looked at in IDLE)
//   abort       drop an in-progress transfer, no done pulse
//   pattern     pattern bits, right-aligned
//   seq_len     number of pattern bits (1..MAX_LEN)
//   repeat_cnt  extra frames after the first
//   gap_len     idle cycles between frames
//   data_out    serial bit, forced to 0 when data_valid is 0
//   data_valid  data_out carries a pattern bit
//   frame_start marks the first bit of every frame
//   busy        transfer in progress
//   done        one-cycle pulse after the last bit of the last frame
//   err         sticky: the most recent start had an illegal seq_len
// -----------------------------------------------------------------------------
module seq_gen #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 5,
    parameter int REP_W   = 4,
    parameter int GAP_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   seq_len,
    input  logic [REP_W-1:0]   repeat_cnt,
    input  logic [GAP_W-1:0]   gap_len,
    output logic               data_out,
    output logic               data_valid,
    output logic               frame_start,
    output logic               busy,
    output logic               done,
    output logic               err
);
    import seq_pkg::*;

    // control state
    state_t             r_state;
    logic [LEN_W-1:0]   r_bit_idx;
    logic [REP_W-1:0]   r_reps;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_fin;
    logic               r_err;

    // registered outputs
    logic               r_dout;
    logic               r_dv;
    logic               r_fs;
    logic               r_busy;
    logic               r_done;

    // shadow copies of the job parameters, captured on an accepted start
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic [GAP_W-1:0]   r_gap;

    // next-state values
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   w_bit_idx_nxt;
    logic [REP_W-1:0]   w_reps_nxt;
    logic [GAP_W-1:0]   w_gap_cnt_nxt;
    logic               w_fin_nxt;
    logic               w_err_nxt;
    logic               w_dout_nxt;
    logic               w_dv_nxt;
    logic               w_fs_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_load;
    logic               w_cur_bit;
    logic [LEN_W-1:0]   w_last_idx;

    // Bit selected by r_bit_idx; mask-and-reduce keeps the index width free
    // of the pattern width.
    assign w_cur_bit  = |(r_pattern & (MAX_LEN'(1) << r_bit_idx));
    assign w_last_idx = r_len - LEN_W'(1);

    // Outputs are a one-cycle registered image of the state being processed,
    // so busy/data_valid appear the cycle after the corresponding edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_idx_nxt = r_bit_idx;
        w_reps_nxt    = r_reps;
        w_gap_cnt_nxt = r_gap_cnt;
        w_fin_nxt     = r_fin;
        w_err_nxt     = r_err;
        w_dout_nxt    = 1'b0;
        w_dv_nxt      = 1'b0;
        w_fs_nxt      = 1'b0;
        w_busy_nxt    = (r_state != IDLE);
        w_done_nxt    = 1'b0;
        w_load        = 1'b0;

        if (ena) begin
            // r_fin marks "last bit just went out"; done follows it by one
            // enabled cycle so it lands after busy has dropped.
            w_fin_nxt  = 1'b0;
            w_done_nxt = r_fin;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (len_legal(32'(seq_len), MAX_LEN)) begin
                            w_err_nxt     = 1'b0;
                            w_load        = 1'b1;
                            w_bit_idx_nxt = seq_len - LEN_W'(1);
                            w_reps_nxt    = repeat_cnt;
                            w_state_nxt   = SEND;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (abort) begin
                        w_state_nxt = IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_dout_nxt = w_cur_bit;
                        w_dv_nxt   = 1'b1;
                        w_fs_nxt   = (r_bit_idx == w_last_idx);
                        if (r_bit_idx != '0) begin
                            w_bit_idx_nxt = r_bit_idx - LEN_W'(1);
                        end else if (r_reps == '0) begin
                            w_state_nxt = IDLE;
                            w_fin_nxt   = 1'b1;
                        end else begin
                            // Reload now; the index simply holds through GAP.
                            w_reps_nxt    = r_reps - REP_W'(1);
                            w_bit_idx_nxt = w_last_idx;
                            if (r_gap != '0) begin
                                w_state_nxt   = GAP;
                                w_gap_cnt_nxt = r_gap - GAP_W'(1);
                            end
                        end
                    end
                end

                GAP: begin
                    if (abort) begin
                        w_state_nxt = IDLE;
                        w_busy_nxt  = 1'b0;
                    end else if (r_gap_cnt == '0) begin
                        w_state_nxt = SEND;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_idx <= '0;
            r_reps    <= '0;
            r_gap_cnt <= '0;
            r_fin     <= 1'b0;
            r_err     <= 1'b0;
            r_dout    <= 1'b0;
            r_dv      <= 1'b0;
            r_fs      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_reps    <= w_reps_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_fin     <= w_fin_nxt;
            r_err     <= w_err_nxt;
            r_dout    <= w_dout_nxt;
            r_dv      <= w_dv_nxt;
            r_fs      <= w_fs_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Shadow registers are pure data: only an accepted start writes them,
    // so they need no reset.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_pattern <= pattern;
            r_len     <= seq_len;
            r_gap     <= gap_len;
        end
    end

    assign data_out    = r_dout;
    assign data_valid  = r_dv;
    assign frame_start = r_fs;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_gen
// Scoreboard bench for seq_gen. Stimulus pushes the expected serial bits
// (value, frame_start flag, cycle of appearance) into a queue; an
// independent monitor pops and compares whenever data_valid is high, and
// checks the line is quiet otherwise. Stimulus also checks busy/done/err.
// -----------------------------------------------------------------------------
module tb_seq_gen;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 5;
    localparam int REP_W   = 4;
    localparam int GAP_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ena;
    logic               start;
    logic               abort;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   seq_len;
    logic [REP_W-1:0]   repeat_cnt;
    logic [GAP_W-1:0]   gap_len;
    logic               data_out;
    logic               data_valid;
    logic               frame_start;
    logic               busy;
    logic               done;
    logic               err;

    seq_gen #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .REP_W   (REP_W),
        .GAP_W   (GAP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .start       (start),
        .abort       (abort),
        .pattern     (pattern),
        .seq_len     (seq_len),
        .repeat_cnt  (repeat_cnt),
        .gap_len     (gap_len),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic b;
        logic fs;
        int   at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_bit(input logic b, input logic fs, input int at);
        exp_t e;
        e.b  = b;
        e.fs = fs;
        e.at = at;
        sb.push_back(e);
    endtask

    task automatic push_frame(input logic [7:0] pat, input int len, input int at0);
        logic [7:0] t;
        for (int i = len - 1; i >= 0; i--) begin
            t = pat >> i;
            push_bit(t[0], (i == len - 1), at0 + (len - 1 - i));
        end
    endtask

    // Called at a negedge; start is sampled at the next posedge (cycle s).
    // Returns at the negedge where cyc == s, with the job inputs scrambled.
    task automatic issue_start(input logic [7:0] pat, input int len, input int rep,
                               input int gap, output int s);
        pattern    = pat;
        seq_len    = 5'(len);
        repeat_cnt = 4'(rep);
        gap_len    = 4'(gap);
        start      = 1'b1;
        s          = cyc + 1;
        @(negedge clk);
        start      = 1'b0;
        pattern    = ~pat;
        seq_len    = 5'd3;
        repeat_cnt = 4'd7;
        gap_len    = 4'd5;
    endtask

    // Walk cycles s+from .. s+done_off checking busy and the done pulse.
    task automatic watch(input int s, input int from, input int done_off);
        for (int k = from; k <= done_off; k++) begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(k < done_off));
            chk("done", 32'(done), 32'(k == done_off));
        end
        chk("watch_cycle", cyc, s + done_off);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_out"},    32'(data_out),    0);
        chk({tag, "_data_valid"},  32'(data_valid),  0);
        chk({tag, "_frame_start"}, 32'(frame_start), 0);
        chk({tag, "_busy"},        32'(busy),        0);
        chk({tag, "_done"},        32'(done),        0);
        chk({tag, "_err"},         32'(err),         0);
    endtask

    // Monitor: every valid bit must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (data_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_bit: got data_valid=1 data_out=%0b, expected no bit (cycle %0d)",
                             data_out, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("bit_value",   32'(data_out),    32'(mon_e.b));
                    chk("frame_start", 32'(frame_start), 32'(mon_e.fs));
                    chk("bit_cycle",   cyc,              mon_e.at);
                end
            end else begin
                chk("data_valid",       32'(data_valid),  0);
                chk("idle_data_out",    32'(data_out),    0);
                chk("idle_frame_start", 32'(frame_start), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        int s;

        rst_n      = 1'b0;
        ena        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        pattern    = '0;
        seq_len    = '0;
        repeat_cnt = '0;
        gap_len    = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // single frame 1011
        issue_start(8'b0000_1011, 4, 0, 0, s);
        push_frame(8'b0000_1011, 4, s + 1);
        watch(s, 1, 5);

        // back-to-back: start in the done cycle; two frames, no gap
        issue_start(8'b0000_1011, 4, 1, 0, s);
        push_frame(8'b0000_1011, 4, s + 1);
        push_frame(8'b0000_1011, 4, s + 5);
        watch(s, 1, 9);

        // two frames with a 2-cycle gap
        issue_start(8'b0000_1011, 4, 1, 2, s);
        push_frame(8'b0000_1011, 4, s + 1);
        push_frame(8'b0000_1011, 4, s + 7);
        watch(s, 1, 11);

        // illegal lengths 0 and 9
        issue_start(8'b0000_1011, 0, 0, 0, s);
        chk("err_len0", 32'(err), 1);
        chk("busy_len0", 32'(busy), 0);
        @(negedge clk);
        chk("busy_len0_next", 32'(busy), 0);
        issue_start(8'b0000_1011, 9, 0, 0, s);
        chk("err_len9", 32'(err), 1);
        @(negedge clk);
        chk("busy_len9_next", 32'(busy), 0);
        chk("err_sticky", 32'(err), 1);
        issue_start(8'b0000_1011, 4, 0, 0, s);
        chk("err_cleared", 32'(err), 0);
        push_frame(8'b0000_1011, 4, s + 1);
        watch(s, 1, 5);

        // ena low for 3 cycles after the 2nd bit
        issue_start(8'b0000_1011, 4, 0, 0, s);
        push_bit(1'b1, 1'b1, s + 1);
        push_bit(1'b0, 1'b0, s + 2);
        push_bit(1'b1, 1'b0, s + 6);
        push_bit(1'b1, 1'b0, s + 7);
        repeat (2) @(negedge clk);
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_busy", 32'(busy), 1);
            chk("stall_done", 32'(done), 0);
        end
        ena = 1'b1;
        watch(s, 6, 8);

        // abort after the 2nd bit
        issue_start(8'b0000_1011, 4, 0, 0, s);
        push_bit(1'b1, 1'b1, s + 1);
        push_bit(1'b0, 1'b0, s + 2);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
            chk("abort_idle_busy", 32'(busy), 0);
        end
        issue_start(8'b0000_1011, 4, 0, 0, s);
        push_frame(8'b0000_1011, 4, s + 1);
        watch(s, 1, 5);

        // reset clears a sticky err
        issue_start(8'b0000_1011, 0, 0, 0, s);
        chk("err_before_reset", 32'(err), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("err_after_reset", 32'(err), 0);

        // reset after the 2nd bit
        issue_start(8'b0000_1011, 4, 0, 0, s);
        push_bit(1'b1, 1'b1, s + 1);
        push_bit(1'b0, 1'b0, s + 2);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("midreset");
        issue_start(8'b0000_1011, 4, 0, 0, s);
        push_frame(8'b0000_1011, 4, s + 1);
        watch(s, 1, 5);

        // start while busy is ignored
        issue_start(8'b0000_1011, 4, 1, 0, s);
        push_frame(8'b0000_1011, 4, s + 1);
        push_frame(8'b0000_1011, 4, s + 5);
        repeat (2) @(negedge clk);
        pattern = 8'hFF;
        seq_len = 5'd2;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        watch(s, 4, 9);

        // one-bit frames: frame_start on every bit
        issue_start(8'hFE, 1, 2, 0, s);
        push_frame(8'hFE, 1, s + 1);
        push_frame(8'hFE, 1, s + 2);
        push_frame(8'hFE, 1, s + 3);
        watch(s, 1, 4);

        // full-width pattern
        issue_start(8'hA5, 8, 0, 0, s);
        push_frame(8'hA5, 8, s + 1);
        watch(s, 1, 9);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
